wheel_encoder_cm: RTL



---
 rtl/wheel_encoder_cm.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/wheel_encoder_cm.sv
// Quadrature wheel-encoder front end: synchronize, glitch-filter and 4x-decode A/B,
// then accumulate signed ticks into a saturating centimetre count with a residual.
module wheel_encoder_cm #(
    parameter int unsigned TICKS_PER_CM  = 20,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        encoderreset,
    output logic [31:0] encoderincm,
    output logic [10:0] sub_cm,
    output logic        dir_fwd,
    output logic        cm_strobe,
    output logic        illegal_err
);

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ILL
    } step_e;

    localparam logic [7:0]  C_LAST    = 8'(FILTER_CYCLES - 1);
    localparam logic [11:0] TICKS_POS = 12'(TICKS_PER_CM);
    localparam logic [11:0] TICKS_NEG = 12'd0 - TICKS_POS;
    localparam logic [31:0] COUNT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] COUNT_MIN = 32'h8000_0000;

    logic [1:0]  meta_q, meta_d;
    logic [1:0]  sync_q, sync_d;
    logic [1:0]  f_q, f_d;
    logic [7:0]  c_q, c_d;
    logic [1:0]  p_q, p_d;
    logic [31:0] count_q, count_d;
    logic [10:0] sub_q, sub_d;
    logic        dir_q, dir_d;
    logic        strobe_q, strobe_d;
    logic        illegal_q, illegal_d;

    step_e       step;
    logic [11:0] n;

    // Two-flop synchronizer on the raw pins, {A,B} ordering throughout.
    always_comb begin
        meta_d = {enc_a, enc_b};
        sync_d = meta_q;
    end

    // A new pin value must persist FILTER_CYCLES consecutive samples to be accepted.
    always_comb begin
        f_d = f_q;
        c_d = c_q;
        if (sync_q == f_q) begin
            c_d = '0;
        end else if (c_q == C_LAST) begin
            f_d = sync_q;
            c_d = '0;
        end else begin
            c_d = c_q + 8'd1;
        end
        p_d = f_q;
    end

    always_comb begin
        case ({p_q, f_q})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: step = STEP_FWD;
            4'b1000, 4'b1110, 4'b0111, 4'b0001: step = STEP_REV;
            4'b0011, 4'b1100, 4'b1001, 4'b0110: step = STEP_ILL;
            default:                            step = STEP_NONE;
        endcase
    end

    always_comb begin
        count_d   = count_q;
        sub_d     = sub_q;
        dir_d     = dir_q;
        strobe_d  = 1'b0;
        illegal_d = illegal_q;
        n         = {sub_q[10], sub_q} + ((step == STEP_FWD) ? 12'd1 : 12'hFFF);
        if (encoderreset) begin
            // Clear dominates any step or wrap in the same cycle; direction is kept.
            count_d   = '0;
            sub_d     = '0;
            illegal_d = 1'b0;
        end else if (step == STEP_ILL) begin
            illegal_d = 1'b1;
        end else if (step == STEP_FWD || step == STEP_REV) begin
            dir_d = (step == STEP_FWD);
            if (n == TICKS_POS) begin
                sub_d = '0;
                if (count_q != COUNT_MAX) begin
                    count_d  = count_q + 32'd1;
                    strobe_d = 1'b1;
                end
            end else if (n == TICKS_NEG) begin
                sub_d = '0;
                if (count_q != COUNT_MIN) begin
                    count_d  = count_q - 32'd1;
                    strobe_d = 1'b1;
                end
            end else begin
                sub_d = n[10:0];
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            meta_q    <= '0;
            sync_q    <= '0;
            f_q       <= '0;
            c_q       <= '0;
            p_q       <= '0;
            count_q   <= '0;
            sub_q     <= '0;
            dir_q     <= 1'b1;
            strobe_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            f_q       <= f_d;
            c_q       <= c_d;
            p_q       <= p_d;
            count_q   <= count_d;
            sub_q     <= sub_d;
            dir_q     <= dir_d;
            strobe_q  <= strobe_d;
            illegal_q <= illegal_d;
        end
    end

    assign encoderincm = count_q;
    assign sub_cm      = sub_q;
    assign dir_fwd     = dir_q;
    assign cm_strobe   = strobe_q;
    assign illegal_err = illegal_q;

endmodule
